// File: rtl/mul8_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-sequenced 8x8 multiplier.
// Also provides the pass-to-(a_sel, b_sel, shift) lookup used by the controller.
package mul_seq_pkg;

    localparam int unsigned NW    = 4;
    localparam int unsigned NSEG  = 2;
    localparam int unsigned OPW   = NW * NSEG;
    localparam int unsigned NPASS = NSEG * NSEG;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [7:0] a_sel;
        logic [7:0] b_sel;
        logic [7:0] shift;
    } pass_sel_t;

    // Pass p covers segment (p / nseg) of a and segment (p % nseg) of b, so the
    // order is lo*lo, lo*hi, hi*lo, hi*hi with shift = (a_sel + b_sel) * nw.
    function automatic pass_sel_t pass_lut(
        input logic [1:0]  p,
        input int unsigned nseg,
        input int unsigned nw
    );
        pass_sel_t s;
        s.a_sel = 8'(p / nseg);
        s.b_sel = 8'(p % nseg);
        s.shift = 8'((s.a_sel + s.b_sel) * nw);
        return s;
    endfunction

endpackage

// File: rtl/mul4x4_array.sv
// Combinational NW x NW unsigned array multiplier: AND partial products
// reduced by rows of ripple full adders, one product bit retired per row.
module mul4x4_array #(
    parameter int unsigned NW = 4
) (
    input  logic [NW-1:0]   a,
    input  logic [NW-1:0]   b,
    output logic [2*NW-1:0] p
);

    logic [NW:0]   row;
    logic [NW-1:0] nxt;
    logic          x;
    logic          y;
    logic          c;

    // row holds the running partial sum plus its carry; its LSB is final after each row
    always_comb begin
        p   = '0;
        nxt = '0;
        x   = 1'b0;
        y   = 1'b0;
        c   = 1'b0;
        row = {1'b0, a & {NW{b[0]}}};
        p[0] = row[0];
        for (int unsigned i = 1; i < NW; i++) begin
            c = 1'b0;
            for (int unsigned j = 0; j < NW; j++) begin
                x      = row[j+1];
                y      = a[j] & b[i];
                nxt[j] = x ^ y ^ c;
                c      = (x & y) | (c & (x ^ y));
            end
            row  = {c, nxt};
            p[i] = row[0];
        end
        p[2*NW-1:NW] = row[NW:1];
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequencer that time-shares one NW x NW multiplier core over NSEG*NSEG passes
// to form a full OPW x OPW unsigned product, with valid/ready on both sides.
module mul8_seq_ctrl #(
    parameter int unsigned NW   = mul_seq_pkg::NW,
    parameter int unsigned NSEG = mul_seq_pkg::NSEG
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NW*NSEG-1:0]       a_in,
    input  logic [NW*NSEG-1:0]       b_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*NW*NSEG-1:0]     prod,
    output logic                     busy,
    output logic [1:0]               pass_idx
);

    import mul_seq_pkg::*;

    localparam int unsigned OPW_L  = NW * NSEG;
    localparam int unsigned ACCW   = 2 * OPW_L;
    localparam logic [1:0]  LAST_P = 2'(NSEG * NSEG - 1);

    state_t            state;
    state_t            state_nxt;
    logic [OPW_L-1:0]  a_reg;
    logic [OPW_L-1:0]  b_reg;
    logic [ACCW-1:0]   acc;
    logic [1:0]        pass_cnt;

    pass_sel_t         sel;
    logic [NW-1:0]     core_a;
    logic [NW-1:0]     core_b;
    logic [2*NW-1:0]   core_p;
    logic [ACCW-1:0]   term;

    mul4x4_array #(.NW(NW)) u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    // Nibble selection and alignment for the current pass
    always_comb begin
        sel    = pass_lut(pass_cnt, NSEG, NW);
        core_a = NW'(a_reg >> (sel.a_sel * NW));
        core_b = NW'(b_reg >> (sel.b_sel * NW));
        term   = ACCW'(core_p) << sel.shift;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)             state_nxt = RUN;
            RUN:     if (pass_cnt == LAST_P)   state_nxt = DONE;
            DONE:    if (out_ready)            state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        pass_idx  = (state == RUN) ? pass_cnt : '0;
        prod      = acc;
    end

    // Operands are captured only on accept, so input changes during a job are ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            pass_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a_in;
                        b_reg    <= b_in;
                        acc      <= '0;
                        pass_cnt <= '0;
                    end
                end
                RUN: begin
                    acc      <= acc + term;
                    pass_cnt <= (pass_cnt == LAST_P) ? '0 : pass_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
